change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Sequences the coin hoppers that pay out change after a vend or a money-return.
- Takes a change amount in cents from the vending_machine datapath and ejects quarters, dimes and nickels one at a time, largest coin first.
- Each ejection is confirmed by a hopper handshake; a hopper that does not respond is retired for the rest of the transaction.
- Reports completion, the number of coins paid and any unpaid residue.

Parameters:
- AMT_W, 7, width of amount and remaining (cents).
- TIMEOUT, 16, cycles eject may stay high without eject_ack before that coin is masked (must be >= 2).
- GAP_CYC, 3, idle cycles between consecutive ejections (hopper settle time, >= 1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to pay out amount; sampled only in IDLE.
- amount  in  AMT_W  change owed in cents; latched on accepted start.
- coin_avail  in  3  hopper stock flags {quarter,dime,nickel}; sampled only in SELECT.
- eject_ack  in  1  hopper coin-sensed pulse; honoured only in EJECT.
- eject  out  3  one-hot eject command {quarter,dime,nickel}, held until ack or timeout.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of transaction.
- fault  out  1  valid with done: 1 = remaining nonzero at finish.
- remaining  out  AMT_W  cents still owed; updated on each ack.
- coins_paid  out  5  coins ejected this transaction (saturates at 31).

Behaviour:
- Reset (async, reset low): state IDLE; eject=0, busy=0, done=0, fault=0, remaining=0, coins_paid=0, mask=0, timers=0.
  - Takes effect mid-EJECT as well: eject drops immediately, with no ack wait and no decrement.
- State register: IDLE, SELECT, EJECT, GAP, DONE. All outputs are registered.
- IDLE, start=1: remaining<=amount, coins_paid<=0, mask<=0, fault<=0; next state SELECT.
  - start in any other state is ignored and not queued.
- SELECT (exactly 1 cycle):
  - remaining==0: go to DONE with fault=0.
  - Otherwise pick the largest coin c with value(c) <= remaining, coin_avail[c]=1 and mask[c]=0. Values: quarter 25, dime 10, nickel 5.
  - Coin found: eject<=onehot(c), timer<=0, next state EJECT.
  - No eligible coin: next state DONE with fault=1.
- EJECT: eject held constant; timer increments every cycle.
  - eject_ack=1: remaining<=remaining-value(c), coins_paid++ (saturating), eject<=0, next state GAP.
  - Else if timer==TIMEOUT-1: mask[c]<=1, eject<=0, remaining unchanged, next state GAP.
  - If ack and timeout coincide, ack wins.
- GAP: eject=0 for GAP_CYC cycles, then SELECT. eject_ack during GAP or IDLE is ignored.
- DONE: done=1 for exactly this one cycle; fault and remaining stay stable until the next accepted start. Next state IDLE, busy=0.
- Latency:
  - start to first eject: 2 cycles (start cycle, then SELECT; eject is high from the 2nd edge).
  - start with amount=0: done pulses 2 cycles after start.
- Arithmetic: subtraction never underflows because the coin is chosen with value <= remaining. An amount not a multiple of 5 ends with fault=1 and remaining = amount mod 5, after all payable coins.
- coin_avail falling during EJECT does not abort the ejection; it only affects the next SELECT.

Decomposition:
- Shared header vending_machine.vh gains:
  - coin value constants VAL_QUARTER=25, VAL_DIME=10, VAL_NICKEL=5;
  - one-hot eject encodings EJ_QUARTER=3'b100, EJ_DIME=3'b010, EJ_NICKEL=3'b001;
  - dispenser state encodings.
- One combinational sub-module, change_coin_select: inputs remaining, coin_avail and mask; outputs one-hot pick and a found flag. It is instantiated for SELECT and unit-tested alone.
- Timers, mask, counters and FSM stay in change_dispenser.

Test Plan:
- Full change: amount=65, coin_avail=3'b111, ack 2 cycles after each eject -> eject sequence Q,Q,D,N; done with fault=0, remaining=0, coins_paid=4; first eject 2 cycles after start.
- Quarter hopper empty: amount=30, coin_avail=3'b011 -> D,D,D; coins_paid=3, fault=0; eject never shows 3'b100.
- Hopper jam: amount=25, all available, no ack while eject=3'b100 -> eject drops after TIMEOUT=16 cycles; then D,D,N with acks; fault=0, coins_paid=3, remaining=0.
- Unpayable residue: amount=7 -> one nickel, then done with fault=1, remaining=2, coins_paid=1. Separately, amount=0 -> done 2 cycles after start, coins_paid=0.
- Protocol abuse: start pulsed during EJECT with amount=99 is ignored (remaining continues from the original 40); eject_ack during GAP does not decrement; ack and timeout in the same cycle count as ack.
- Reset mid-operation: reset low while eject=3'b010 -> eject, busy and remaining are 0 asynchronously; after release, a new start with amount=10 pays one dime normally.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// Shared coin constants, eject encodings and dispenser state type for the
// change payout path of the vending machine.
package change_dispenser_pkg;

  localparam int VAL_QUARTER = 25;
  localparam int VAL_DIME    = 10;
  localparam int VAL_NICKEL  = 5;

  localparam logic [2:0] EJ_QUARTER = 3'b100;
  localparam logic [2:0] EJ_DIME    = 3'b010;
  localparam logic [2:0] EJ_NICKEL  = 3'b001;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_EJECT  = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4
  } disp_state_e;

  // Cent value of a one-hot eject command; zero for anything else.
  function automatic logic [4:0] coin_value(input logic [2:0] ej);
    case (ej)
      EJ_QUARTER: coin_value = 5'(VAL_QUARTER);
      EJ_DIME:    coin_value = 5'(VAL_DIME);
      EJ_NICKEL:  coin_value = 5'(VAL_NICKEL);
      default:    coin_value = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/change_coin_select.sv
// Picks the largest coin that still fits in the owed amount, is stocked and
// has not been retired by a hopper timeout this transaction.
module change_coin_select
  import change_dispenser_pkg::*;
#(
  parameter int AMT_W = 7
) (
  input  logic [AMT_W-1:0] remaining_i,
  input  logic [2:0]       coin_avail_i,
  input  logic [2:0]       mask_i,
  output logic [2:0]       pick_o,
  output logic             found_o
);

  logic [2:0] elig;

  always_comb begin
    elig[2] = (remaining_i >= AMT_W'(VAL_QUARTER)) && coin_avail_i[2] && !mask_i[2];
    elig[1] = (remaining_i >= AMT_W'(VAL_DIME))    && coin_avail_i[1] && !mask_i[1];
    elig[0] = (remaining_i >= AMT_W'(VAL_NICKEL))  && coin_avail_i[0] && !mask_i[0];
    pick_o  = 3'b000;
    if (elig[2])      pick_o = EJ_QUARTER;
    else if (elig[1]) pick_o = EJ_DIME;
    else if (elig[0]) pick_o = EJ_NICKEL;
    found_o = |elig;
  end

endmodule

// File: rtl/change_dispenser.sv
// Change payout sequencer: ejects coins largest-first with a per-coin ack
// handshake, retiring hoppers that time out, and reports the unpaid residue.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int AMT_W   = 7,
  parameter int TIMEOUT = 16,
  parameter int GAP_CYC = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [AMT_W-1:0] amount_i,
  input  logic [2:0]       coin_avail_i,
  input  logic             eject_ack_i,
  output logic [2:0]       eject_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             fault_o,
  output logic [AMT_W-1:0] remaining_o,
  output logic [4:0]       coins_paid_o
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  disp_state_e      state_q, state_d;
  logic [2:0]       eject_q, eject_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [4:0]       paid_q, paid_d;
  logic [2:0]       mask_q, mask_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [GW-1:0]    gap_q, gap_d;

  logic [2:0]       pick;
  logic             found;

  change_coin_select #(.AMT_W(AMT_W)) u_sel (
    .remaining_i  (rem_q),
    .coin_avail_i (coin_avail_i),
    .mask_i       (mask_q),
    .pick_o       (pick),
    .found_o      (found)
  );

  always_comb begin
    state_d = state_q;
    eject_d = eject_q;
    fault_d = fault_q;
    rem_d   = rem_q;
    paid_d  = paid_q;
    mask_d  = mask_q;
    tmr_d   = tmr_q;
    gap_d   = gap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          rem_d   = amount_i;
          paid_d  = '0;
          mask_d  = '0;
          fault_d = 1'b0;
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (rem_q == '0) begin
          fault_d = 1'b0;
          state_d = ST_DONE;
        end else if (found) begin
          eject_d = pick;
          tmr_d   = '0;
          state_d = ST_EJECT;
        end else begin
          fault_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_EJECT: begin
        tmr_d = tmr_q + 1'b1;
        // Ack is checked first so a coin sensed on the timeout cycle still counts.
        if (eject_ack_i) begin
          rem_d   = rem_q - AMT_W'(coin_value(eject_q));
          if (paid_q != 5'd31) paid_d = paid_q + 5'd1;
          eject_d = '0;
          gap_d   = '0;
          state_d = ST_GAP;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          mask_d  = mask_q | eject_q;
          eject_d = '0;
          gap_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GW'(GAP_CYC - 1)) state_d = ST_SELECT;
        else                           gap_d   = gap_q + 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      eject_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      rem_q   <= '0;
      paid_q  <= '0;
      mask_q  <= '0;
      tmr_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      eject_q <= eject_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      rem_q   <= rem_d;
      paid_q  <= paid_d;
      mask_q  <= mask_d;
      tmr_q   <= tmr_d;
      gap_q   <= gap_d;
    end
  end

  assign eject_o      = eject_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign fault_o      = fault_q;
  assign remaining_o  = rem_q;
  assign coins_paid_o = paid_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: selector vector table, transaction
// table driven through a scripted hopper responder, and a mid-eject reset.
module tb_change_dispenser;

  localparam logic [2:0] Q = 3'b100;
  localparam logic [2:0] D = 3'b010;
  localparam logic [2:0] N = 3'b001;
  localparam logic [2:0] X = 3'b000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [6:0] amount;
  logic [2:0] avail;
  logic       ack;
  logic [2:0] eject;
  logic       busy, done, fault;
  logic [6:0] remaining;
  logic [4:0] paid;

  logic [6:0] s_rem;
  logic [2:0] s_avail, s_mask, s_pick;
  logic       s_found;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  change_dispenser #(.AMT_W(7), .TIMEOUT(16), .GAP_CYC(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .amount_i(amount),
    .coin_avail_i(avail), .eject_ack_i(ack), .eject_o(eject), .busy_o(busy),
    .done_o(done), .fault_o(fault), .remaining_o(remaining), .coins_paid_o(paid)
  );

  change_coin_select #(.AMT_W(7)) u_sel (
    .remaining_i(s_rem), .coin_avail_i(s_avail), .mask_i(s_mask),
    .pick_o(s_pick), .found_o(s_found)
  );

  typedef struct {
    logic [6:0] rem;
    logic [2:0] avail;
    logic [2:0] mask;
    logic [2:0] pick;
    logic       found;
  } sel_t;

  typedef struct {
    logic [6:0]  amount;
    logic [2:0]  avail;
    logic [2:0]  jam;      // coins the responder never acks
    int          ack_at;   // ack asserted on this cycle of eject being high
    bit          gap_ack;  // hold ack high whenever eject is low
    bit          abuse;    // pulse start(amount=99) during first eject
    logic [23:0] seq;      // expected eject order, first coin in LSBs
    int          len;
    logic [4:0]  paid;
    logic        fault;
    logic [6:0]  rem;
    int          first;    // expected cycle of first eject (0 = skip)
    int          maxhi;    // expected longest eject-high run (0 = skip)
    int          done_at;  // expected done cycle (0 = skip)
  } txn_t;

  sel_t sv[11];
  txn_t tv[11];

  function automatic logic [23:0] sq(input logic [2:0] c0, c1, c2, c3);
    sq = {12'b0, c3, c2, c1, c0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_txn(input int idx, input txn_t t);
    logic [23:0] seq = '0;
    int len = 0, cyc = 0, first = 0, age = 0, maxhi = 0, done_cyc = 0;
    bit got_done = 0, abused = 0;
    logic [2:0] prev = '0;
    logic [6:0] rem_at_done = '0;
    @(negedge clk);
    start = 1'b1; amount = t.amount; avail = t.avail; ack = 1'b0;
    while (!got_done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (eject != 3'b000) begin
        if (prev == 3'b000 && len < 8) begin
          seq[3*len +: 3] = eject;
          len++;
          if (first == 0) first = cyc;
        end
        age++;
        if (age > maxhi) maxhi = age;
        ack = (age == t.ack_at) && ((eject & t.jam) == 3'b000);
        if (t.abuse && !abused) begin
          start = 1'b1; amount = 7'd99; abused = 1;
        end
      end else begin
        age = 0;
        ack = t.gap_ack;
      end
      prev = eject;
      if (done) begin
        got_done = 1; done_cyc = cyc;
        chk($sformatf("t%0d.busy_at_done", idx), 32'(busy), 32'd1);
        chk($sformatf("t%0d.fault", idx), 32'(fault), 32'(t.fault));
        chk($sformatf("t%0d.remaining", idx), 32'(remaining), 32'(t.rem));
        chk($sformatf("t%0d.coins_paid", idx), 32'(paid), 32'(t.paid));
        rem_at_done = remaining;
      end
    end
    ack = 1'b0;
    chk($sformatf("t%0d.done_seen", idx), 32'(got_done), 32'd1);
    chk($sformatf("t%0d.eject_seq", idx), 32'(seq), 32'(t.seq));
    chk($sformatf("t%0d.eject_count", idx), 32'(len), 32'(t.len));
    if (t.first != 0)   chk($sformatf("t%0d.first_eject_cyc", idx), 32'(first), 32'(t.first));
    if (t.maxhi != 0)   chk($sformatf("t%0d.eject_high_cycles", idx), 32'(maxhi), 32'(t.maxhi));
    if (t.done_at != 0) chk($sformatf("t%0d.done_cyc", idx), 32'(done_cyc), 32'(t.done_at));
    @(negedge clk);
    chk($sformatf("t%0d.done_pulse_len", idx), 32'(done), 32'd0);
    chk($sformatf("t%0d.idle_busy", idx), 32'(busy), 32'd0);
    chk($sformatf("t%0d.rem_stable", idx), 32'(remaining), 32'(t.rem));
    chk($sformatf("t%0d.fault_stable", idx), 32'(fault), 32'(t.fault));
    if (got_done) chk($sformatf("t%0d.rem_hold", idx), 32'(remaining), 32'(rem_at_done));
  endtask

  initial begin
    txn_t rt;
    bit seen;
    rst_n = 1'b0; start = 1'b0; amount = '0; avail = 3'b111; ack = 1'b0;
    s_rem = '0; s_avail = '0; s_mask = '0;

    // Selector unit vectors: remaining, avail, mask -> pick, found
    sv[0]  = '{7'd65,  3'b111, 3'b000, Q, 1'b1};
    sv[1]  = '{7'd24,  3'b111, 3'b000, D, 1'b1};
    sv[2]  = '{7'd9,   3'b111, 3'b000, N, 1'b1};
    sv[3]  = '{7'd4,   3'b111, 3'b000, X, 1'b0};
    sv[4]  = '{7'd30,  3'b011, 3'b000, D, 1'b1};
    sv[5]  = '{7'd30,  3'b111, 3'b100, D, 1'b1};
    sv[6]  = '{7'd25,  3'b100, 3'b000, Q, 1'b1};
    sv[7]  = '{7'd20,  3'b101, 3'b000, N, 1'b1};
    sv[8]  = '{7'd0,   3'b111, 3'b000, X, 1'b0};
    sv[9]  = '{7'd127, 3'b000, 3'b000, X, 1'b0};
    sv[10] = '{7'd10,  3'b011, 3'b010, N, 1'b1};

    // amount avail jam ack_at gap abuse seq len paid fault rem first maxhi done_at
    tv[0]  = '{7'd65, 3'b111, 3'b000, 2,  0, 0, sq(Q,Q,D,N), 4, 5'd4, 1'b0, 7'd0,  2, 2,  0};
    tv[1]  = '{7'd30, 3'b011, 3'b000, 2,  0, 0, sq(D,D,D,X), 3, 5'd3, 1'b0, 7'd0,  2, 2,  0};
    tv[2]  = '{7'd25, 3'b111, 3'b100, 2,  0, 0, sq(Q,D,D,N), 4, 5'd3, 1'b0, 7'd0,  2, 16, 0};
    tv[3]  = '{7'd7,  3'b111, 3'b000, 2,  0, 0, sq(N,X,X,X), 1, 5'd1, 1'b1, 7'd2,  2, 2,  0};
    tv[4]  = '{7'd0,  3'b111, 3'b000, 2,  0, 0, sq(X,X,X,X), 0, 5'd0, 1'b0, 7'd0,  0, 0,  2};
    tv[5]  = '{7'd40, 3'b111, 3'b000, 2,  0, 1, sq(Q,D,N,X), 3, 5'd3, 1'b0, 7'd0,  2, 2,  0};
    tv[6]  = '{7'd40, 3'b111, 3'b000, 2,  1, 0, sq(Q,D,N,X), 3, 5'd3, 1'b0, 7'd0,  2, 2,  0};
    tv[7]  = '{7'd25, 3'b111, 3'b000, 16, 0, 0, sq(Q,X,X,X), 1, 5'd1, 1'b0, 7'd0,  2, 16, 0};
    tv[8]  = '{7'd15, 3'b001, 3'b000, 2,  0, 0, sq(N,N,N,X), 3, 5'd3, 1'b0, 7'd0,  2, 2,  0};
    tv[9]  = '{7'd10, 3'b100, 3'b000, 2,  0, 0, sq(X,X,X,X), 0, 5'd0, 1'b1, 7'd10, 0, 0,  2};
    tv[10] = '{7'd5,  3'b001, 3'b001, 2,  0, 0, sq(N,X,X,X), 1, 5'd0, 1'b1, 7'd5,  2, 16, 0};

    for (int i = 0; i < 11; i++) begin
      s_rem = sv[i].rem; s_avail = sv[i].avail; s_mask = sv[i].mask;
      #1;
      chk($sformatf("sel%0d.pick", i), 32'(s_pick), 32'(sv[i].pick));
      chk($sformatf("sel%0d.found", i), 32'(s_found), 32'(sv[i].found));
    end

    #3;
    chk("reset.eject", 32'(eject), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.fault", 32'(fault), 32'd0);
    chk("reset.remaining", 32'(remaining), 32'd0);
    chk("reset.coins_paid", 32'(paid), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_txn(i, tv[i]);

    // Reset while the dime hopper is being commanded, then a clean dime payout.
    @(negedge clk);
    start = 1'b1; amount = 7'd10; avail = 3'b111; ack = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (eject == D) seen = 1;
    end
    chk("rst_mid.dime_ejecting", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.eject", 32'(eject), 32'd0);
    chk("rst_mid.busy", 32'(busy), 32'd0);
    chk("rst_mid.remaining", 32'(remaining), 32'd0);
    chk("rst_mid.coins_paid", 32'(paid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rt = '{7'd10, 3'b111, 3'b000, 2, 0, 0, sq(D,X,X,X), 1, 5'd1, 1'b0, 7'd0, 2, 2, 0};
    run_txn(99, rt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
